// File: rtl/ext_bus_mailbox_target_if.sv
// External bus bundle: ce/oe/we strobes, word address, data both ways.
// master drives strobes and write data; slave returns registered read data.
interface ext_bus_mailbox_target_if;
  logic [3:0]  ext_bus_ce;
  logic        ext_bus_oe;
  logic        ext_bus_we;
  logic [23:0] ext_bus_address;
  logic [31:0] ext_bus_write_data;
  logic [31:0] ext_bus_read_data;
  logic        ext_bus_read_data_enable;

  modport master (
    output ext_bus_ce,
    output ext_bus_oe,
    output ext_bus_we,
    output ext_bus_address,
    output ext_bus_write_data,
    input  ext_bus_read_data,
    input  ext_bus_read_data_enable
  );

  modport slave (
    input  ext_bus_ce,
    input  ext_bus_oe,
    input  ext_bus_we,
    input  ext_bus_address,
    input  ext_bus_write_data,
    output ext_bus_read_data,
    output ext_bus_read_data_enable
  );
endinterface

// File: rtl/ext_bus_mailbox_target.sv
// Bus target: mailbox FIFO, reply register, scratch and status words.
// Each strobe assertion gives exactly one side effect via edge detect.
module ext_bus_mailbox_target #(
  parameter int CE_INDEX  = 0,
  parameter int FIFO_LOG2 = 2
) (
  input  logic        int_clock,
  input  logic        int_reset,
  ext_bus_mailbox_target_if.slave ext_bus,
  output logic [31:0] mailbox_data,
  output logic        mailbox_valid,
  input  logic        mailbox_ack,
  input  logic [31:0] reply_data_in,
  input  logic        reply_write
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef logic [FIFO_LOG2-1:0] ptr_t;
  typedef logic [FIFO_LOG2:0]   cnt_t;

  logic        sel, wr, rd;
  logic        prev_wr, prev_rd;
  logic        wr_event, rd_event;
  logic [1:0]  addr;
  logic        unused_addr;

  logic [31:0] mem [DEPTH];
  ptr_t        wptr, rptr;
  cnt_t        count;
  logic        empty, full;
  logic        push_req, push_ok, pop;
  logic        overflow, overflow_set, overflow_clr;

  logic [31:0] scratch;
  logic [31:0] reply;
  logic        reply_full, reply_overrun;
  logic        reply_clr, overrun_clr;

  logic [31:0] status_word;
  logic [31:0] rd_mux;

  assign sel  = ext_bus.ext_bus_ce[CE_INDEX];
  assign wr   = sel & ext_bus.ext_bus_we;
  assign rd   = sel & ext_bus.ext_bus_oe & ~ext_bus.ext_bus_we;
  assign addr = ext_bus.ext_bus_address[1:0];

  assign unused_addr = &{1'b0, ext_bus.ext_bus_address[23:2]};

  assign wr_event = wr & ~prev_wr;
  assign rd_event = rd & ~prev_rd;

  assign empty = (count == '0);
  assign full  = (count == cnt_t'(DEPTH));

  assign mailbox_valid = ~empty;
  assign mailbox_data  = mem[rptr];

  assign pop      = mailbox_ack & ~empty;
  assign push_req = wr_event & (addr == 2'd1);
  assign push_ok  = push_req & (~full | pop);

  assign overflow_set = push_req & full & ~pop;
  assign overflow_clr = wr_event & (addr == 2'd0) &
                        ext_bus.ext_bus_write_data[16];
  assign overrun_clr  = wr_event & (addr == 2'd0) &
                        ext_bus.ext_bus_write_data[17];
  assign reply_clr    = rd_event & (addr == 2'd3);

  // Strobe history; held high in reset so a strobe across release is inert.
  always_ff @(posedge int_clock) begin
    if (int_reset) begin
      prev_wr <= 1'b1;
      prev_rd <= 1'b1;
    end else begin
      prev_wr <= wr;
      prev_rd <= rd;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge int_clock) begin
    if (push_ok) mem[wptr] <= ext_bus.ext_bus_write_data;
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge int_clock) begin
    if (int_reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + ptr_t'(1);
      if (pop)     rptr <= rptr + ptr_t'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
      overflow <= overflow_set | (overflow & ~overflow_clr);
    end
  end

  // Scratch word and reply channel; a local write beats a bus read clear.
  always_ff @(posedge int_clock) begin
    if (int_reset) begin
      scratch       <= '0;
      reply         <= '0;
      reply_full    <= 1'b0;
      reply_overrun <= 1'b0;
    end else begin
      if (wr_event && addr == 2'd2) scratch <= ext_bus.ext_bus_write_data;
      if (reply_write) reply <= reply_data_in;
      reply_full    <= reply_write | (reply_full & ~reply_clr);
      reply_overrun <= (reply_write & reply_full) |
                       (reply_overrun & ~overrun_clr);
    end
  end

  // Status word assembly and read mux by register address.
  always_comb begin
    status_word              = '0;
    status_word[FIFO_LOG2:0] = count;
    status_word[8]           = empty;
    status_word[9]           = full;
    status_word[12]          = reply_full;
    status_word[16]          = overflow;
    status_word[17]          = reply_overrun;
    rd_mux = '0;
    unique case (addr)
      2'd0: rd_mux = status_word;
      2'd1: rd_mux[FIFO_LOG2:0] = count;
      2'd2: rd_mux = scratch;
      2'd3: rd_mux = reply;
      default: rd_mux = '0;
    endcase
  end

  // Registered read return, refreshed every cycle the read strobe is high.
  always_ff @(posedge int_clock) begin
    if (int_reset) begin
      ext_bus.ext_bus_read_data        <= '0;
      ext_bus.ext_bus_read_data_enable <= 1'b0;
    end else if (rd) begin
      ext_bus.ext_bus_read_data        <= rd_mux;
      ext_bus.ext_bus_read_data_enable <= 1'b1;
    end else begin
      ext_bus.ext_bus_read_data        <= '0;
      ext_bus.ext_bus_read_data_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ext_bus_mailbox_target.sv
// Directed bench for ext_bus_mailbox_target.
// Instance a decodes ce[0]; instance b decodes ce[2].
module tb_ext_bus_mailbox_target;

  logic        int_clock = 1'b0;
  logic        int_reset = 1'b1;

  logic [31:0] a_mb_data, b_mb_data;
  logic        a_mb_valid, b_mb_valid;
  logic        a_ack = 1'b0;
  logic [31:0] a_rep_in = '0;
  logic        a_rep_wr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rdata;
  logic        ren;

  ext_bus_mailbox_target_if bus_a();
  ext_bus_mailbox_target_if bus_b();

  ext_bus_mailbox_target #(.CE_INDEX(0), .FIFO_LOG2(2)) dut_a (
    .int_clock     (int_clock),
    .int_reset     (int_reset),
    .ext_bus       (bus_a),
    .mailbox_data  (a_mb_data),
    .mailbox_valid (a_mb_valid),
    .mailbox_ack   (a_ack),
    .reply_data_in (a_rep_in),
    .reply_write   (a_rep_wr)
  );

  ext_bus_mailbox_target #(.CE_INDEX(2), .FIFO_LOG2(2)) dut_b (
    .int_clock     (int_clock),
    .int_reset     (int_reset),
    .ext_bus       (bus_b),
    .mailbox_data  (b_mb_data),
    .mailbox_valid (b_mb_valid),
    .mailbox_ack   (1'b0),
    .reply_data_in (32'h0),
    .reply_write   (1'b0)
  );

  always #5 int_clock = ~int_clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge int_clock);
    #1;
  endtask

  task automatic drive(input bit b, input logic [3:0] ce,
                       input logic oe, input logic we,
                       input logic [23:0] ad, input logic [31:0] wd);
    if (b) begin
      bus_b.ext_bus_ce = ce;
      bus_b.ext_bus_oe = oe;
      bus_b.ext_bus_we = we;
      bus_b.ext_bus_address = ad;
      bus_b.ext_bus_write_data = wd;
    end else begin
      bus_a.ext_bus_ce = ce;
      bus_a.ext_bus_oe = oe;
      bus_a.ext_bus_we = we;
      bus_a.ext_bus_address = ad;
      bus_a.ext_bus_write_data = wd;
    end
  endtask

  task automatic bus_write(input bit b, input logic [3:0] ce,
                           input logic [23:0] ad,
                           input logic [31:0] wd, input int hold);
    drive(b, ce, 1'b0, 1'b1, ad, wd);
    repeat (hold) tick();
    drive(b, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    tick();
  endtask

  task automatic bus_read(input bit b, input logic [3:0] ce,
                          input logic [23:0] ad,
                          output logic [31:0] d, output logic en);
    drive(b, ce, 1'b1, 1'b0, ad, 32'h0);
    tick();
    d  = b ? bus_b.ext_bus_read_data : bus_a.ext_bus_read_data;
    en = b ? bus_b.ext_bus_read_data_enable
           : bus_a.ext_bus_read_data_enable;
    drive(b, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    tick();
  endtask

  task automatic rd_a(input string tag, input logic [23:0] ad,
                      input logic [31:0] exp);
    bus_read(1'b0, 4'h1, ad, rdata, ren);
    check({tag, "_en"}, {31'h0, ren}, 32'h1);
    check(tag, rdata, exp);
  endtask

  task automatic pop_a(input string tag, input logic [31:0] exp);
    check(tag, a_mb_data, exp);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
  endtask

  initial begin
    drive(1'b0, 4'h1, 1'b0, 1'b1, 24'h1, 32'h55);
    drive(1'b1, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    repeat (3) tick();
    check("rst_rden", {31'h0, bus_a.ext_bus_read_data_enable}, 32'h0);
    check("rst_rdata", bus_a.ext_bus_read_data, 32'h0);
    int_reset = 1'b0;
    repeat (2) tick();
    check("rst_no_push", {31'h0, a_mb_valid}, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    tick();
    rd_a("rst_status", 24'h0, 32'h100);

    bus_write(1'b0, 4'h1, 24'h1, 32'hDEADBEEF, 3);
    check("held_valid", {31'h0, a_mb_valid}, 32'h1);
    check("held_data", a_mb_data, 32'hDEADBEEF);
    rd_a("held_count", 24'h1, 32'h1);
    rd_a("held_status", 24'h0, 32'h1);
    pop_a("held_pop", 32'hDEADBEEF);
    check("held_empty", {31'h0, a_mb_valid}, 32'h0);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    rd_a("ack_empty", 24'h0, 32'h100);

    for (int i = 1; i <= 5; i++)
      bus_write(1'b0, 4'h1, 24'h1, i, 1);
    rd_a("ovf_status", 24'h0, 32'h10204);
    for (int i = 1; i <= 4; i++)
      pop_a($sformatf("ovf_pop%0d", i), i);
    rd_a("ovf_drained", 24'h0, 32'h10100);
    bus_write(1'b0, 4'h1, 24'h0, 32'h10000, 1);
    rd_a("ovf_cleared", 24'h0, 32'h100);

    for (int i = 10; i <= 13; i++)
      bus_write(1'b0, 4'h1, 24'hABC001, i, 1);
    rd_a("pp_full", 24'h0, 32'h204);
    drive(1'b0, 4'h1, 1'b0, 1'b1, 24'h1, 32'd14);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    tick();
    rd_a("pp_status", 24'h0, 32'h204);
    for (int i = 11; i <= 14; i++)
      pop_a($sformatf("pp_pop%0d", i), i);

    drive(1'b0, 4'h1, 1'b0, 1'b1, 24'h1, 32'h77);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    tick();
    rd_a("pe_count", 24'h1, 32'h1);
    pop_a("pe_data", 32'h77);

    a_rep_in = 32'h12345678;
    a_rep_wr = 1'b1;
    tick();
    a_rep_wr = 1'b0;
    rd_a("rep_full", 24'h0, 32'h1100);
    rd_a("rep_read", 24'h3, 32'h12345678);
    rd_a("rep_cleared", 24'h0, 32'h100);
    a_rep_in = 32'hAAAA0001;
    a_rep_wr = 1'b1;
    tick();
    a_rep_in = 32'hBBBB0002;
    tick();
    a_rep_wr = 1'b0;
    rd_a("rep_overrun", 24'h0, 32'h21100);
    rd_a("rep_newest", 24'h3, 32'hBBBB0002);
    bus_write(1'b0, 4'h1, 24'h0, 32'h20000, 1);
    rd_a("rep_ovr_clr", 24'h0, 32'h100);

    a_rep_in = 32'hD0D0D0D0;
    a_rep_wr = 1'b1;
    tick();
    a_rep_in = 32'hE0E0E0E0;
    drive(1'b0, 4'h1, 1'b1, 1'b0, 24'h3, 32'h0);
    tick();
    a_rep_wr = 1'b0;
    check("ww_old_data", bus_a.ext_bus_read_data, 32'hD0D0D0D0);
    drive(1'b0, 4'h1, 1'b1, 1'b0, 24'h2, 32'h0);
    tick();
    check("track_addr", bus_a.ext_bus_read_data, 32'h0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 24'h0, 32'h0);
    tick();
    check("rd_drop_en", {31'h0, bus_a.ext_bus_read_data_enable}, 32'h0);
    rd_a("ww_status", 24'h0, 32'h21100);
    rd_a("ww_new_data", 24'h3, 32'hE0E0E0E0);

    bus_write(1'b1, 4'h1, 24'h2, 32'h11111111, 1);
    bus_write(1'b1, 4'h1, 24'h1, 32'h22222222, 1);
    check("cs_no_push", {31'h0, b_mb_valid}, 32'h0);
    bus_read(1'b1, 4'h1, 24'h2, rdata, ren);
    check("cs_no_en", {31'h0, ren}, 32'h0);
    bus_read(1'b1, 4'h4, 24'h2, rdata, ren);
    check("cs_scratch0", rdata, 32'h0);
    bus_write(1'b1, 4'h4, 24'h2, 32'hA5A5A5A5, 2);
    bus_read(1'b1, 4'h4, 24'h2, rdata, ren);
    check("cs_en", {31'h0, ren}, 32'h1);
    check("cs_scratch", rdata, 32'hA5A5A5A5);
    bus_read(1'b1, 4'h4, 24'h0, rdata, ren);
    check("cs_status", rdata, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ext_bus_mailbox_target.md
Name: ext_bus_mailbox_target

Overview:
- Responder on the external bus: the target end of the ce/oe/we/address/data bus driven by the gip_simple initiator.
- Decodes one chip select and exposes four word registers to the bus:
  - a bus-to-local mailbox FIFO
  - a local-to-bus reply register
  - a scratch register
  - a status register
- Sits beside memory on the external bus, in FPGA fabric or as a bench model. Gives the processor a handshaked message channel to local logic.

Parameters:
CE_INDEX, 0, chip-select bit (0..3) this target responds to
FIFO_LOG2, 2, log2 of mailbox FIFO depth (default depth 4)

Ports:
int_clock  input  1  single clock, all state on rising edge
int_reset  input  1  synchronous, active-high reset
ext_bus_ce  input  4  active-high chip selects
ext_bus_oe  input  1  active-high output enable (read strobe)
ext_bus_we  input  1  active-high write enable (write strobe)
ext_bus_address  input  24  word address; bits [1:0] select the register, upper bits ignored
ext_bus_write_data  input  32  write data from initiator
ext_bus_read_data  output  32  registered read data
ext_bus_read_data_enable  output  1  high when this target drives read data
mailbox_data  output  32  head of mailbox FIFO
mailbox_valid  output  1  FIFO not empty
mailbox_ack  input  1  local pop of head when mailbox_valid
reply_data_in  input  32  local reply word
reply_write  input  1  local strobe loading reply_data_in

Behaviour:
- Strobes and edge detection:
  - sel = ext_bus_ce[CE_INDEX]; wr = sel & we; rd = sel & oe & !we.
  - Registered prev_wr and prev_rd. wr_event = wr & !prev_wr; rd_event = rd & !prev_rd.
  - Exactly one side effect per strobe assertion, however many cycles the strobe is held.
- Reset: all of the following cleared to 0:
  - FIFO pointers/count, overflow, reply_full, reply_overrun, scratch, reply register
  - ext_bus_read_data, ext_bus_read_data_enable
  - prev_wr and prev_rd are set to 1, so a strobe held across reset release causes no access.
- Register map, by address[1:0]:
  - 0 STATUS:
    - Read: [FIFO_LOG2:0]=count, [8]=empty, [9]=full, [12]=reply_full, [16]=overflow (sticky), [17]=reply_overrun (sticky), other bits 0.
    - Write: a 1 in bit 16 or bit 17 clears that flag; other bits ignored.
  - 1 MAILBOX:
    - Write pushes ext_bus_write_data on wr_event.
    - Read returns count in [FIFO_LOG2:0], zero-extended; no side effect.
  - 2 SCRATCH: read/write 32-bit register, written on wr_event.
  - 3 REPLY:
    - Read returns the reply register.
    - rd_event clears reply_full. A write is ignored.
- Read timing:
  - Each cycle rd is high: ext_bus_read_data <= mux(address[1:0]) and ext_bus_read_data_enable <= 1.
  - Otherwise both are <= 0.
  - Latency is 1 cycle from rd; data tracks address changes while rd is held.
- FIFO:
  - Depth 2^FIFO_LOG2, count width FIFO_LOG2+1.
  - mailbox_data is combinational from the head entry; mailbox_valid = !empty.
  - Pop occurs when mailbox_ack & mailbox_valid; mailbox_ack while empty is ignored.
- FIFO boundary conditions:
  - Push when full and no pop in the same cycle: data dropped, overflow set to 1.
  - Push and pop in the same cycle while full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only, count becomes 1.
  - Pointers wrap modulo depth.
  - A bus clear of overflow in the same cycle as a new overflow leaves overflow set (set wins).
- Reply:
  - reply_write loads reply_data_in and sets reply_full.
  - reply_write while reply_full is already set: overwrite and set reply_overrun.
  - reply_write in the same cycle as the REPLY rd_event: the new data loads and reply_full stays 1 (write wins). The bus read returns the old value.

Test Plan:
- Reset: hold int_reset with ce[0]=1, we=1 across release -> no push, count=0, STATUS read returns 0x100 one cycle after rd.
- Held strobe: write 0xDEADBEEF to address 1, holding we 3 cycles -> single push, mailbox_valid=1, mailbox_data=0xDEADBEEF, count=1.
- Fill and overflow: push 5 words 1..5 with no ack -> STATUS=0x10204 (count 4, full, overflow). Pops yield 1,2,3,4. Write 0x10000 to STATUS -> overflow cleared.
- Simultaneous push/pop when full: ack asserted in the wr_event cycle -> count stays 4, overflow 0, head advances.
- Reply: reply_write with 0x12345678 -> STATUS bit 12=1. Bus read of address 3 returns 0x12345678 one cycle later and clears reply_full. Second reply_write before the read -> reply_overrun=1.
- Chip select decode: with CE_INDEX=2, accesses on ce[0] -> no state change, ext_bus_read_data_enable stays 0. Scratch write/read of 0xA5A5A5A5 on ce[2] returns the same value.
